// File: rtl/udp_tx_loader_if.sv
// udp_tx_loader_if: app byte stream, payload RAM write port and sender
// control/status signals of the UDP transmit loader.
interface udp_tx_loader_if;
  logic [7:0]  app_data;
  logic        app_valid;
  logic        app_last;
  logic        app_ready;
  logic        ram_wr_en;
  logic [10:0] ram_wr_addr;
  logic [31:0] ram_wr_data;
  logic [15:0] tx_data_length;
  logic [15:0] tx_total_length;
  logic        send_trigger;
  logic [3:0]  tx_state;
  logic        frame_drop;

  modport master (
    output app_data, app_valid, app_last, tx_state,
    input  app_ready, ram_wr_en, ram_wr_addr, ram_wr_data,
    input  tx_data_length, tx_total_length, send_trigger, frame_drop
  );

  modport slave (
    input  app_data, app_valid, app_last, tx_state,
    output app_ready, ram_wr_en, ram_wr_addr, ram_wr_data,
    output tx_data_length, tx_total_length, send_trigger, frame_drop
  );
endinterface

// File: rtl/udp_tx_loader.sv
// udp_tx_loader: packs app bytes big-endian into 32-bit payload RAM words,
// pads short frames, computes UDP/IP lengths and triggers the sender.
module udp_tx_loader #(
  parameter int MAX_BYTES     = 1472,
  parameter int MIN_PAYLOAD   = 18,
  parameter int START_TIMEOUT = 255
) (
  input  logic           e_rxc,
  input  logic           reset_n,
  udp_tx_loader_if.slave bus
);
  localparam logic [2:0] S_LOAD = 3'd0;
  localparam logic [2:0] S_PAD  = 3'd1;
  localparam logic [2:0] S_LEN  = 3'd2;
  localparam logic [2:0] S_TRIG = 3'd3;
  localparam logic [2:0] S_WST  = 3'd4;
  localparam logic [2:0] S_WDN  = 3'd5;

  localparam logic [10:0] LP_MAX = 11'(MAX_BYTES);
  localparam logic [10:0] LP_MIN = 11'(MIN_PAYLOAD);
  localparam logic [15:0] LP_TMO = 16'(START_TIMEOUT - 1);

  logic [2:0]  r_state;
  logic        r_rdy;
  logic [10:0] r_cnt;
  logic        r_ovf;
  logic [31:0] r_word;
  logic [10:0] r_nwords;
  logic [15:0] r_tmr;
  logic        r_wr_en;
  logic [10:0] r_wr_addr;
  logic [31:0] r_wr_data;
  logic [15:0] r_dlen;
  logic [15:0] r_tlen;
  logic        r_drop;

  logic        w_xfer;
  logic        w_ovf;
  logic [1:0]  w_lane;
  logic [31:0] w_word;
  logic [10:0] w_p;
  logic [10:0] w_need;

  assign bus.app_ready       = r_rdy & (r_state == S_LOAD);
  assign bus.ram_wr_en       = r_wr_en;
  assign bus.ram_wr_addr     = r_wr_addr;
  assign bus.ram_wr_data     = r_wr_data;
  assign bus.tx_data_length  = r_dlen;
  assign bus.tx_total_length = r_tlen;
  assign bus.send_trigger    = (r_state == S_TRIG);
  assign bus.frame_drop      = r_drop;

  assign w_xfer = bus.app_valid & bus.app_ready;
  assign w_lane = r_cnt[1:0];
  assign w_ovf  = r_ovf | (r_cnt == LP_MAX);
  assign w_p    = (r_cnt < LP_MIN) ? LP_MIN : r_cnt;
  assign w_need = (w_p + 11'd3) >> 2;

  // lane 0 restarts the word, so unused low lanes are always zero
  always_comb begin
    w_word = 32'h0;
    case (w_lane)
      2'd0:    w_word = {bus.app_data, 24'h0};
      2'd1:    w_word = {r_word[31:24], bus.app_data, 16'h0};
      2'd2:    w_word = {r_word[31:16], bus.app_data, 8'h0};
      default: w_word = {r_word[31:8], bus.app_data};
    endcase
  end

  always_ff @(posedge e_rxc or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_LOAD;
      r_rdy     <= 1'b0;
      r_cnt     <= 11'd0;
      r_ovf     <= 1'b0;
      r_word    <= 32'h0;
      r_nwords  <= 11'd0;
      r_tmr     <= 16'd0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= 11'd0;
      r_wr_data <= 32'h0;
      r_dlen    <= 16'd0;
      r_tlen    <= 16'd0;
      r_drop    <= 1'b0;
    end else begin
      r_rdy   <= 1'b1;
      r_wr_en <= 1'b0;
      r_drop  <= 1'b0;
      case (r_state)
        S_LOAD: begin
          if (w_xfer) begin
            if (!w_ovf) begin
              r_word <= w_word;
              r_cnt  <= r_cnt + 11'd1;
              if (w_lane == 2'd3 || bus.app_last) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= {2'b00, r_cnt[10:2]};
                r_wr_data <= w_word;
              end
            end else begin
              r_ovf <= 1'b1;
            end
            if (bus.app_last) begin
              if (w_ovf) begin
                r_drop <= 1'b1;
                r_cnt  <= 11'd0;
                r_ovf  <= 1'b0;
              end else begin
                r_nwords <= {2'b00, r_cnt[10:2]} + 11'd1;
                r_state  <= S_PAD;
              end
            end
          end
        end
        S_PAD: begin
          if (r_nwords < w_need) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_nwords;
            r_wr_data <= 32'h0;
            r_nwords  <= r_nwords + 11'd1;
            if (r_nwords + 11'd1 >= w_need) r_state <= S_LEN;
          end else begin
            r_state <= S_LEN;
          end
        end
        S_LEN: begin
          r_dlen  <= {5'd0, w_p} + 16'd8;
          r_tlen  <= {5'd0, w_p} + 16'd28;
          r_tmr   <= 16'd0;
          r_state <= S_TRIG;
        end
        S_TRIG: r_state <= S_WST;
        S_WST: begin
          if (bus.tx_state != 4'd0) begin
            r_state <= S_WDN;
          end else if (r_tmr == LP_TMO) begin
            r_drop   <= 1'b1;
            r_cnt    <= 11'd0;
            r_ovf    <= 1'b0;
            r_nwords <= 11'd0;
            r_state  <= S_LOAD;
          end else begin
            r_tmr <= r_tmr + 16'd1;
          end
        end
        S_WDN: begin
          if (bus.tx_state == 4'd0) begin
            r_cnt    <= 11'd0;
            r_ovf    <= 1'b0;
            r_nwords <= 11'd0;
            r_state  <= S_LOAD;
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_udp_tx_loader.sv
// tb_udp_tx_loader: frame table plus hand sequences; RAM writes are
// checked against a scoreboard filled by a byte-level packing model.
module tb_udp_tx_loader;
  localparam int MAXB = 1472;
  localparam int MINP = 18;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  udp_tx_loader_if bus();

  udp_tx_loader dut (
    .e_rxc  (clk),
    .reset_n(rst_n),
    .bus    (bus)
  );

  typedef struct packed {
    logic [10:0] a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    int         len;
    logic [7:0] base;
    int         dlen;
    int         tlen;
    bit         drop;
  } vec_t;

  wr_t  sb[$];
  wr_t  e;
  vec_t vt[8];
  vec_t vr;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int trig_cnt = 0;
  int drop_cnt = 0;
  int trig_cyc = 0;
  int drop_cyc = 0;
  logic [15:0] exp_dlen = 16'd0;
  logic [15:0] exp_tlen = 16'd0;
  logic [31:0] m_word = 32'h0;
  int m_cnt = 0;
  bit m_ovf = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (bus.ram_wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                 bus.ram_wr_addr, bus.ram_wr_data);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", 32'(bus.ram_wr_addr), 32'(e.a));
        chk("wr_data", bus.ram_wr_data, e.d);
      end
    end
    if (bus.send_trigger === 1'b1) begin
      trig_cnt++;
      trig_cyc = cyc;
      chk("udp_len", 32'(bus.tx_data_length), 32'(exp_dlen));
      chk("ip_len", 32'(bus.tx_total_length), 32'(exp_tlen));
      chk("writes_before_trig", 32'(sb.size()), 32'd0);
    end
    if (bus.frame_drop === 1'b1) begin
      drop_cnt++;
      drop_cyc = cyc;
    end
  end

  task automatic model_byte(input logic [7:0] d, input bit last);
    int p;
    if (m_cnt < MAXB) begin
      m_word[31-8*(m_cnt%4) -: 8] = d;
      if (m_cnt % 4 == 3 || last) begin
        sb.push_back({11'(m_cnt/4), m_word});
        m_word = 32'h0;
      end
      m_cnt++;
    end else begin
      m_ovf = 1'b1;
    end
    if (last) begin
      if (!m_ovf) begin
        p = (m_cnt < MINP) ? MINP : m_cnt;
        for (int w = (m_cnt + 3) / 4; w < (p + 3) / 4; w++)
          sb.push_back({11'(w), 32'h0});
      end
      m_cnt  = 0;
      m_ovf  = 1'b0;
      m_word = 32'h0;
    end
  endtask

  task automatic send(input int n, input logic [7:0] base, input bit with_last);
    int j = 0;
    int t = 0;
    while (j < n && t < 4000) begin
      @(negedge clk);
      bus.app_valid = 1'b1;
      bus.app_data  = base + 8'(j);
      bus.app_last  = with_last && (j == n - 1);
      if (bus.app_ready === 1'b1) begin
        model_byte(bus.app_data, bus.app_last);
        j++;
      end
      t++;
    end
    if (j < n) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: got %0d bytes expected %0d", j, n);
    end
    @(negedge clk);
    bus.app_valid = 1'b0;
    bus.app_last  = 1'b0;
  endtask

  task automatic wait_trig(input int t0);
    int k = 0;
    while (trig_cnt == t0 && k < 3000) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("trigger_seen", 32'(trig_cnt - t0), 32'd1);
  endtask

  task automatic run_frame(input vec_t v);
    int t0;
    int d0;
    int k;
    t0 = trig_cnt;
    d0 = drop_cnt;
    exp_dlen = 16'(v.dlen);
    exp_tlen = 16'(v.tlen);
    send(v.len, v.base, 1'b1);
    if (v.drop) begin
      repeat (4) @(negedge clk);
      #1;
      chk("drop_pulse", 32'(drop_cnt - d0), 32'd1);
      chk("drop_no_trig", 32'(trig_cnt - t0), 32'd0);
      chk("drop_writes", 32'(sb.size()), 32'd0);
      chk("drop_ready", 32'(bus.app_ready), 32'd1);
    end else begin
      wait_trig(t0);
      bus.tx_state = 4'd3;
      repeat (6) begin
        @(negedge clk);
        #1;
        chk("ready_busy", 32'(bus.app_ready), 32'd0);
      end
      bus.tx_state = 4'd0;
      k = 0;
      while (bus.app_ready !== 1'b1 && k < 10) begin
        @(negedge clk);
        #1;
        k++;
      end
      chk("ready_after_done", 32'(bus.app_ready), 32'd1);
      chk("trig_once", 32'(trig_cnt - t0), 32'd1);
      chk("no_drop", 32'(drop_cnt - d0), 32'd0);
      chk("writes_drained", 32'(sb.size()), 32'd0);
      chk("udp_len_hold", 32'(bus.tx_data_length), 32'(v.dlen));
    end
  endtask

  initial begin
    int t0;
    int d0;
    int k;
    int dt;
    vt[0] = '{8,    8'h01, 26,   46,   1'b0};
    vt[1] = '{1,    8'hAB, 26,   46,   1'b0};
    vt[2] = '{100,  8'h10, 108,  128,  1'b0};
    vt[3] = '{1473, 8'h00, 0,    0,    1'b1};
    vt[4] = '{4,    8'h40, 26,   46,   1'b0};
    vt[5] = '{18,   8'h80, 26,   46,   1'b0};
    vt[6] = '{21,   8'h90, 29,   49,   1'b0};
    vt[7] = '{1472, 8'h07, 1480, 1500, 1'b0};

    bus.app_data  = 8'h0;
    bus.app_valid = 1'b0;
    bus.app_last  = 1'b0;
    bus.tx_state  = 4'd0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 32'(bus.app_ready), 32'd0);
    chk("rst_wr_en", 32'(bus.ram_wr_en), 32'd0);
    chk("rst_trig", 32'(bus.send_trigger), 32'd0);
    chk("rst_drop", 32'(bus.frame_drop), 32'd0);
    chk("rst_udp_len", 32'(bus.tx_data_length), 32'd0);
    chk("rst_addr", 32'(bus.ram_wr_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_at_release", 32'(bus.app_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("ready_after_release", 32'(bus.app_ready), 32'd1);

    for (int i = 0; i < 8; i++) run_frame(vt[i]);

    // sender never leaves idle
    t0 = trig_cnt;
    d0 = drop_cnt;
    exp_dlen = 16'd26;
    exp_tlen = 16'd46;
    send(8, 8'h31, 1'b1);
    wait_trig(t0);
    k = 0;
    while (drop_cnt == d0 && k < 400) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("timeout_drop", 32'(drop_cnt - d0), 32'd1);
    dt = drop_cyc - trig_cyc;
    chk("timeout_cycles_in_range", 32'(dt >= 255 && dt <= 257), 32'd1);
    @(negedge clk);
    #1;
    chk("timeout_ready", 32'(bus.app_ready), 32'd1);
    chk("timeout_one_trig", 32'(trig_cnt - t0), 32'd1);

    // reset in the middle of a frame
    send(5, 8'h50, 1'b0);
    @(negedge clk);
    chk("pre_reset_writes", 32'(sb.size()), 32'd0);
    t0 = trig_cnt;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(bus.app_ready), 32'd0);
    chk("mid_rst_wr_en", 32'(bus.ram_wr_en), 32'd0);
    chk("mid_rst_udp_len", 32'(bus.tx_data_length), 32'd0);
    chk("mid_rst_ip_len", 32'(bus.tx_total_length), 32'd0);
    chk("mid_rst_data", bus.ram_wr_data, 32'd0);
    m_cnt  = 0;
    m_ovf  = 1'b0;
    m_word = 32'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_rst_no_trig", 32'(trig_cnt - t0), 32'd0);
    vr = '{4, 8'hC0, 26, 46, 1'b0};
    run_frame(vr);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1);
  end
endmodule
